// File: rtl/pc_ras_unit_if.sv
// Control-side bundle for pc_ras_unit: select/call/stall in, PC and RAS status out.
interface pc_ras_unit_if #(
    parameter int WIDTH     = 32,
    parameter int OFFSET_W  = 16,
    parameter int RAS_DEPTH = 4
);
    localparam int CNT_W = $clog2(RAS_DEPTH) + 1;

    logic                stall;
    logic [OFFSET_W-1:0] id;
    logic [WIDTH-1:0]    jt;
    logic [2:0]          pcsel;
    logic                call;
    logic [WIDTH-1:0]    pc;
    logic [WIDTH-1:0]    pc_inc;
    logic [WIDTH-1:0]    pc_offset;
    logic [CNT_W-1:0]    ras_count;
    logic                ras_overflow;
    logic                ras_miss;
    logic                misalign;

    modport master (
        output stall, id, jt, pcsel, call,
        input  pc, pc_inc, pc_offset, ras_count, ras_overflow, ras_miss, misalign
    );

    modport slave (
        input  stall, id, jt, pcsel, call,
        output pc, pc_inc, pc_offset, ras_count, ras_overflow, ras_miss, misalign
    );
endinterface

// File: rtl/pc_ras_unit.sv
// Next-PC generator with stall hold and a circular return-address stack.
// Optional macro PC_ALIGN_CHECK_EN: misaligned JMP/RET-fallback traps to ILLOP_VEC.
module pc_ras_unit #(
    parameter int               WIDTH     = 32,
    parameter int               OFFSET_W  = 16,
    parameter int               RAS_DEPTH = 4,
    parameter logic [WIDTH-1:0] RESET_VEC = 32'h80000000,
    parameter logic [WIDTH-1:0] ILLOP_VEC = 32'h80000004,
    parameter logic [WIDTH-1:0] XADR_VEC  = 32'h80000008
) (
    input  logic            clock,
    input  logic            reset_n,
    pc_ras_unit_if.slave    bus
);
    localparam int PTR_W = $clog2(RAS_DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] pc_q, pc_d;
    logic [PTR_W-1:0] sp_q, sp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             miss_q, miss_d;
    logic             mis_q, mis_d;
    logic [WIDTH-1:0] ras_q [RAS_DEPTH];

    logic [WIDTH-1:0] pc_inc, pc_offset, jmp_tgt, ret_tgt, top;
    logic [WIDTH-2:0] id_ext;
    logic [PTR_W-1:0] top_ptr, wr_ptr;
    logic             wr_en, push_req, pop, jmp_req, empty, full;

    assign id_ext    = {{(WIDTH-1-OFFSET_W){bus.id[OFFSET_W-1]}}, bus.id};
    assign pc_inc    = {pc_q[WIDTH-1], pc_q[WIDTH-2:0] + (WIDTH-1)'(4)};
    assign pc_offset = {pc_q[WIDTH-1], pc_inc[WIDTH-2:0] + (id_ext << 2)};
    // Jumps and returns can only keep or drop the supervisor bit, never raise it.
    assign jmp_tgt   = {bus.jt[WIDTH-1] & pc_q[WIDTH-1], bus.jt[WIDTH-2:2], 2'b00};
    assign top_ptr   = sp_q - PTR_W'(1);
    assign top       = ras_q[top_ptr];
    assign ret_tgt   = {top[WIDTH-1] & pc_q[WIDTH-1], top[WIDTH-2:0]};
    assign empty     = (cnt_q == '0);
    assign full      = (cnt_q == CNT_W'(RAS_DEPTH));

`ifndef PC_ALIGN_CHECK_EN
    logic unused_jt_low;
    assign unused_jt_low = ^bus.jt[1:0];
`endif

    always_comb begin
        pc_d     = pc_q;
        sp_d     = sp_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        miss_d   = 1'b0;
        mis_d    = 1'b0;
        push_req = 1'b0;
        pop      = 1'b0;
        jmp_req  = 1'b0;
        wr_en    = 1'b0;
        wr_ptr   = sp_q;

        case (bus.pcsel)
            3'd0: if (!bus.stall) pc_d = pc_inc;
            3'd1: if (!bus.stall) begin
                pc_d     = pc_offset;
                push_req = bus.call;
            end
            3'd2: if (!bus.stall) begin
                jmp_req  = 1'b1;
                push_req = bus.call;
            end
            3'd5: if (!bus.stall) begin
                push_req = bus.call;
                if (empty) begin
                    jmp_req = 1'b1;
                    miss_d  = 1'b1;
                end else begin
                    pop  = 1'b1;
                    pc_d = ret_tgt;
                end
            end
            3'd4:    pc_d = XADR_VEC;
            default: pc_d = ILLOP_VEC;
        endcase

        if (jmp_req) begin
`ifdef PC_ALIGN_CHECK_EN
            if (bus.jt[1:0] != 2'b00) begin
                pc_d     = ILLOP_VEC;
                mis_d    = 1'b1;
                push_req = 1'b0;
            end else begin
                pc_d = jmp_tgt;
            end
`else
            pc_d = jmp_tgt;
`endif
        end

        // Pop+push rewrites the top slot in place; a plain push may wrap over the oldest.
        if (push_req) begin
            wr_en = 1'b1;
            if (pop) begin
                wr_ptr = top_ptr;
            end else begin
                wr_ptr = sp_q;
                sp_d   = sp_q + PTR_W'(1);
                if (full) ovf_d = 1'b1;
                else      cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (pop) begin
            sp_d  = top_ptr;
            cnt_d = cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc_q   <= RESET_VEC;
            sp_q   <= '0;
            cnt_q  <= '0;
            ovf_q  <= 1'b0;
            miss_q <= 1'b0;
            mis_q  <= 1'b0;
        end else begin
            pc_q   <= pc_d;
            sp_q   <= sp_d;
            cnt_q  <= cnt_d;
            ovf_q  <= ovf_d;
            miss_q <= miss_d;
            mis_q  <= mis_d;
        end
    end

    // Stack storage carries no reset; validity is tracked by cnt_q alone.
    always_ff @(posedge clock) begin
        if (wr_en) ras_q[wr_ptr] <= pc_inc;
    end

    assign bus.pc           = pc_q;
    assign bus.pc_inc       = pc_inc;
    assign bus.pc_offset    = pc_offset;
    assign bus.ras_count    = cnt_q;
    assign bus.ras_overflow = ovf_q;
    assign bus.ras_miss     = miss_q;
    assign bus.misalign     = mis_q;
endmodule

// File: tb/tb_pc_ras_unit.sv
// Directed table-driven bench for pc_ras_unit plus hand-written multi-cycle sequences.
module tb_pc_ras_unit;
    logic clock;
    logic reset_n;
    int   n_chk = 0;
    int   n_fail = 0;

    pc_ras_unit_if #(.WIDTH(32), .OFFSET_W(16), .RAS_DEPTH(4)) bus ();

    pc_ras_unit #(.WIDTH(32), .OFFSET_W(16), .RAS_DEPTH(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic        stall;
        logic [15:0] id;
        logic [31:0] jt;
        logic [2:0]  pcsel;
        logic        call;
        logic [31:0] pc;
        logic [2:0]  cnt;
        logic        ovf;
        logic        miss;
        logic        mis;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(logic st, logic [15:0] id, logic [31:0] jt, logic [2:0] sel,
                                logic call, logic [31:0] pc, logic [2:0] cnt, logic ovf,
                                logic miss, logic mis);
        vec_t v;
        v.stall = st; v.id = id; v.jt = jt; v.pcsel = sel; v.call = call;
        v.pc = pc; v.cnt = cnt; v.ovf = ovf; v.miss = miss; v.mis = mis;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [15:0] id, input logic [31:0] jt,
                         input logic [2:0] sel, input logic call);
        bus.stall = st; bus.id = id; bus.jt = jt; bus.pcsel = sel; bus.call = call;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0;
        #2;
        reset_n = 1'b1;
        #1;
    endtask

    initial begin
        drive(0, 16'h0, 32'h0, 3'd0, 0);
        reset_n = 1'b0;
        #12;
        chk("reset_pc", bus.pc, 32'h80000000);
        chk("reset_cnt", 32'(bus.ras_count), 32'd0);
        chk("reset_ovf", 32'(bus.ras_overflow), 32'd0);
        chk("reset_miss", 32'(bus.ras_miss), 32'd0);
        chk("reset_mis", 32'(bus.misalign), 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        //           st id        jt            sel call pc            cnt ovf miss mis
        tbl.push_back(mk(0, 16'h0,    32'h0,        0, 0, 32'h80000004, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h0,        0, 0, 32'h80000008, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h0,        0, 0, 32'h8000000C, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h0,        0, 0, 32'h80000010, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'hFFFF, 32'h0,        1, 0, 32'h80000010, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0002, 32'h0,        1, 0, 32'h8000001C, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h00000100, 2, 0, 32'h00000100, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h80000200, 2, 0, 32'h00000200, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h0,        4, 0, 32'h80000008, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h0,        7, 0, 32'h80000004, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h0,        6, 0, 32'h80000004, 0, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h0,        3, 0, 32'h80000004, 0, 0, 0, 0));
        // five calls; return addresses 80000008,104,204,304,404 (first one overwritten)
        tbl.push_back(mk(0, 16'h0,    32'h00000100, 2, 1, 32'h00000100, 1, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h00000200, 2, 1, 32'h00000200, 2, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h00000300, 2, 1, 32'h00000300, 3, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h00000400, 2, 1, 32'h00000400, 4, 0, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h00000500, 2, 1, 32'h00000500, 4, 1, 0, 0));
        tbl.push_back(mk(1, 16'h0,    32'h00000600, 2, 1, 32'h00000500, 4, 1, 0, 0));
        tbl.push_back(mk(1, 16'h0,    32'h0,        5, 1, 32'h00000500, 4, 1, 0, 0));
        tbl.push_back(mk(1, 16'h0,    32'h0,        0, 0, 32'h00000500, 4, 1, 0, 0));
        tbl.push_back(mk(1, 16'h0004, 32'h0,        1, 1, 32'h00000500, 4, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h0,        5, 0, 32'h00000404, 3, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h0,        5, 0, 32'h00000304, 2, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h0,        5, 0, 32'h00000204, 1, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h0,        5, 0, 32'h00000104, 0, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h00000040, 5, 0, 32'h00000040, 0, 1, 1, 0));
        tbl.push_back(mk(0, 16'h0,    32'h0,        0, 0, 32'h00000044, 0, 1, 0, 0));
        tbl.push_back(mk(1, 16'h0,    32'h0,        3, 1, 32'h80000004, 0, 1, 0, 0));
        tbl.push_back(mk(1, 16'h0,    32'h0,        4, 1, 32'h80000008, 0, 1, 0, 0));
`ifdef PC_ALIGN_CHECK_EN
        tbl.push_back(mk(0, 16'h0,    32'h00000102, 2, 1, 32'h80000004, 0, 1, 0, 1));
        tbl.push_back(mk(0, 16'h0,    32'h0,        0, 0, 32'h80000008, 0, 1, 0, 0));
`else
        tbl.push_back(mk(0, 16'h0,    32'h00000102, 2, 1, 32'h00000100, 1, 1, 0, 0));
        tbl.push_back(mk(0, 16'h0,    32'h0,        0, 0, 32'h00000104, 1, 1, 0, 0));
`endif

        for (int i = 0; i < tbl.size(); i++) begin
            drive(tbl[i].stall, tbl[i].id, tbl[i].jt, tbl[i].pcsel, tbl[i].call);
            if (i == 4) begin
                #1;
                chk("br_pc_inc", bus.pc_inc, 32'h80000014);
                chk("br_pc_offset_neg", bus.pc_offset, 32'h80000010);
            end
            if (i == 5) begin
                #1;
                chk("br_pc_offset_pos", bus.pc_offset, 32'h8000001C);
            end
            step();
            chk($sformatf("v%0d_pc", i), bus.pc, tbl[i].pc);
            chk($sformatf("v%0d_cnt", i), 32'(bus.ras_count), 32'(tbl[i].cnt));
            chk($sformatf("v%0d_ovf", i), 32'(bus.ras_overflow), 32'(tbl[i].ovf));
            chk($sformatf("v%0d_miss", i), 32'(bus.ras_miss), 32'(tbl[i].miss));
            chk($sformatf("v%0d_mis", i), 32'(bus.misalign), 32'(tbl[i].mis));
        end

        // Asynchronous reset takes effect without a clock edge.
        @(negedge clock);
        #1;
        reset_n = 1'b0;
        #1;
        chk("async_pc", bus.pc, 32'h80000000);
        chk("async_cnt", 32'(bus.ras_count), 32'd0);
        chk("async_ovf", 32'(bus.ras_overflow), 32'd0);
        #1;
        reset_n = 1'b1;

        // RET+call on a non-empty stack replaces the top in place.
        do_reset();
        drive(0, 16'h0, 32'h00000100, 3'd2, 1);
        step();
        chk("rc_call_pc", bus.pc, 32'h00000100);
        chk("rc_call_cnt", 32'(bus.ras_count), 32'd1);
        drive(0, 16'h0, 32'h00000000, 3'd5, 1);
        step();
        chk("rc_retcall_pc", bus.pc, 32'h00000004);
        chk("rc_retcall_cnt", 32'(bus.ras_count), 32'd1);
        drive(0, 16'h0, 32'h0, 3'd5, 0);
        step();
        chk("rc_ret_pc", bus.pc, 32'h00000104);
        chk("rc_ret_cnt", 32'(bus.ras_count), 32'd0);

        // RET+call on an empty stack falls back to jt and still pushes.
        drive(0, 16'h0, 32'h00000040, 3'd5, 1);
        step();
        chk("ec_pc", bus.pc, 32'h00000040);
        chk("ec_cnt", 32'(bus.ras_count), 32'd1);
        chk("ec_miss", 32'(bus.ras_miss), 32'd1);
        drive(0, 16'h0, 32'h0, 3'd0, 0);
        step();
        chk("ec_seq_pc", bus.pc, 32'h00000044);
        chk("ec_miss_clear", 32'(bus.ras_miss), 32'd0);
        drive(0, 16'h0, 32'h0, 3'd5, 0);
        step();
        chk("ec_ret_pc", bus.pc, 32'h00000108);
        chk("ec_ret_cnt", 32'(bus.ras_count), 32'd0);
        chk("ec_ovf", 32'(bus.ras_overflow), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/pc_ras_unit.md
Name: pc_ras_unit

Overview:
Parametrised next-generation program counter for the RISC core. It generates next-PC for sequential, branch, jump, trap and interrupt flow, as the current pc block does. It adds a pipeline stall hold, a return-address stack (RAS) serving a new RET select, and configurable width and vectors. It sits between the control unit (pcsel/call/stall) and instruction fetch.

Parameters:
WIDTH, 32, PC width; bit WIDTH-1 is the supervisor bit
OFFSET_W, 16, branch literal width (id)
RAS_DEPTH, 4, return-address stack entries (power of two, >=2)
RESET_VEC, 32'h80000000, PC after reset
ILLOP_VEC, 32'h80000004, illegal-op trap target
XADR_VEC, 32'h80000008, interrupt target

Ports:
clock  in  1  system clock, rising edge
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold PC and RAS for non-trap selects
id  in  OFFSET_W  signed word offset for branches
jt  in  WIDTH  jump target (register value)
pcsel  in  3  0 seq, 1 branch, 2 JMP, 3 ILLOP, 4 XADR, 5 RET, 6/7 treated as ILLOP
call  in  1  push pc_inc on a taken branch/JMP/RET update
pc  out  WIDTH  current PC
pc_inc  out  WIDTH  pc + 4 (comb)
pc_offset  out  WIDTH  branch target (comb)
ras_count  out  clog2(RAS_DEPTH)+1  valid RAS entries
ras_overflow  out  1  sticky: push onto full RAS
ras_miss  out  1  one-cycle pulse: RET on empty RAS
misalign  out  1  one-cycle pulse (see Optional Feature)

Behaviour:
- Reset (reset_n low, async): pc=RESET_VEC; ras_count=0; ras_overflow=0; ras_miss=0; misalign=0; RAS contents don't-care.
- pc_inc = {pc[W-1], pc[W-2:0]+4}: supervisor bit preserved, low bits wrap modulo 2^(W-1).
- pc_offset = {pc[W-1], pc_inc[W-2:0] + (sext(id)<<2)}, same wrap rule.
- Next pc, applied at rising edge:
  - 0: pc_inc.
  - 1: pc_offset.
  - 2: {jt[W-1]&pc[W-1], jt[W-2:2], 2'b00}. Jumps never raise privilege.
  - 3/6/7: ILLOP_VEC.
  - 4: XADR_VEC.
  - 5: popped RAS top, supervisor bit ANDed with pc[W-1]. If the RAS is empty: behave as select 2 (jt) and pulse ras_miss.
- Stall:
  - stall=1 with pcsel 0/1/2/5: pc, RAS, and flags unchanged; call ignored.
  - pcsel 3/4 always take effect regardless of stall; the RAS is untouched.
- Push: call=1 with an effective update and pcsel in {1,2,5} pushes the current pc_inc. call with pcsel 0/3/4 is ignored.
- Full push: the RAS is a circular buffer. The oldest entry is overwritten, ras_count stays RAS_DEPTH, and ras_overflow is set (sticky until reset).
- RET+call in the same cycle: pop and push in one edge. The top is replaced by pc_inc; ras_count is unchanged. If empty: the jt fallback is taken and the push proceeds (count 0->1).
- Latency: one cycle select-to-pc; outputs pc_inc/pc_offset combinational from pc and id.
- Reset mid-operation discards RAS state immediately (asynchronous).

Optional Feature:
PC_ALIGN_CHECK_EN.
- Defined: a JMP or RET-fallback with jt[1:0]!=0 goes to ILLOP_VEC instead, pulses misalign for one cycle, and does not push even if call=1.
- Not defined: jt[1:0] is silently masked to 00 and misalign is tied to 0.

Test Plan:
- Reset and sequential: release reset_n, hold pcsel=0 for 3 edges -> pc 0x80000000, 0x80000004, 0x80000008, 0x8000000C; async reset_n low mid-cycle -> pc=0x80000000 without a clock edge.
- Branch: pc=0x80000010, id=16'hFFFF, pcsel=1 -> pc_inc=0x80000014, pc_offset=0x80000010, pc stays 0x80000010; id=16'h0002 -> pc=0x8000001C.
- Privilege: from supervisor, jt=0x00000100, pcsel=2 -> pc=0x00000100; then jt=0x80000200 -> pc=0x00000200. pcsel=4 -> 0x80000008; pcsel=7 -> 0x80000004.
- Call/return with RAS_DEPTH=4:
  - Five JMP+call from known PCs -> ras_overflow=1, ras_count=4.
  - Four RETs -> return addresses of calls 5,4,3,2 in order.
  - Fifth RET with jt=0x40 -> pc=0x40, ras_miss pulses one cycle.
- Stall: stall=1 with pcsel=2 and call=1 -> pc and ras_count unchanged; stall=1 with pcsel=3 -> pc=0x80000004.
- Alignment: jt=0x102, pcsel=2 -> with PC_ALIGN_CHECK_EN pc=0x80000004 and misalign=1; without it pc=0x100 and misalign=0.
